sanmoku_referee: RTL

// - Move-consumer side of the sanmoku move interface: accepts cell moves from both players over a valid/ready handshake.
// - Checks each move for legality, keeps the 3x3 board and whose turn it is, and reports X win, O win or draw.
// - Sits between the user keypad/move source and the computer-player FSM.
// - Acts as the single authoritative board for display and scoring.

---
 rtl/sanmoku_referee_if.sv | 20 ++
 rtl/sanmoku_referee.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sanmoku_referee_if.sv
// Move handshake between a move source (keypad or computer player) and the referee.
// The source drives valid/player/cell; the referee answers with ready and ack/err pulses.
interface sanmoku_referee_if;
   logic       mv_valid;
   logic       mv_player;
   logic [3:0] mv_cell;
   logic       mv_ready;
   logic       mv_ack;
   logic       mv_err;

   modport master (
      output mv_valid, mv_player, mv_cell,
      input  mv_ready, mv_ack, mv_err
   );

   modport slave (
      input  mv_valid, mv_player, mv_cell,
      output mv_ready, mv_ack, mv_err
   );
endinterface

// File: rtl/sanmoku_referee.sv
// 3x3 sanmoku referee: validates moves, owns the board and turn, scores win/draw.
// Optional per-turn forfeit timer is built when REF_TIMEOUT_EN is defined.
module sanmoku_referee #(
   parameter logic        FIRST_PLAYER   = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic             CLK,
   input  logic             RST,
   sanmoku_referee_if.slave mv,
   output logic [8:0]       board_x,
   output logic [8:0]       board_o,
   output logic             turn,
   output logic             isNotEnd,
   output logic [1:0]       winner,
   output logic [7:0]       win_line
);

   typedef enum logic [2:0] {WAIT, CHECK, WIN_X, WIN_O, DRAW} state_t;

   state_t     state, state_nxt;
   logic       xfer, legal, forfeit, timeout_hit;
   logic [8:0] cell_bit;
   logic [7:0] lines_mover;
   logic [3:0] move_cnt;
   logic       ack_r, err_r;

   // Bit k set when line k is fully owned in the given occupancy map.
   function automatic logic [7:0] full_lines(input logic [8:0] b);
      logic [7:0] l;
      l[0] = b[0] & b[1] & b[2];
      l[1] = b[3] & b[4] & b[5];
      l[2] = b[6] & b[7] & b[8];
      l[3] = b[0] & b[3] & b[6];
      l[4] = b[1] & b[4] & b[7];
      l[5] = b[2] & b[5] & b[8];
      l[6] = b[0] & b[4] & b[8];
      l[7] = b[2] & b[4] & b[6];
      return l;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= WAIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      xfer        = 1'b0;
      legal       = 1'b0;
      forfeit     = 1'b0;
      cell_bit    = 9'd1 << mv.mv_cell;
      lines_mover = full_lines(turn ? board_o : board_x);
      case (state)
         WAIT: begin
            xfer  = mv.mv_valid;
            legal = xfer && (mv.mv_player == turn) && (mv.mv_cell <= 4'd8) &&
                    ((cell_bit & (board_x | board_o)) == 9'd0);
            if (legal) begin
               state_nxt = CHECK;
            end else if (timeout_hit && !xfer) begin
               forfeit   = 1'b1;
               state_nxt = turn ? WIN_X : WIN_O;
            end
         end
         CHECK: begin
            if (lines_mover != 8'd0) state_nxt = turn ? WIN_O : WIN_X;
            else if (move_cnt == 4'd9) state_nxt = DRAW;
            else                       state_nxt = WAIT;
         end
         default: state_nxt = state;
      endcase
   end

   assign mv.mv_ready = (state == WAIT);
   assign mv.mv_ack   = ack_r;
   assign mv.mv_err   = err_r;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         board_x  <= 9'd0;
         board_o  <= 9'd0;
         turn     <= FIRST_PLAYER;
         isNotEnd <= 1'b1;
         winner   <= 2'b00;
         win_line <= 8'd0;
         move_cnt <= 4'd0;
         ack_r    <= 1'b0;
         err_r    <= 1'b0;
      end else begin
         ack_r <= legal;
         err_r <= xfer && !legal;
         if (legal) begin
            if (turn) board_o <= board_o | cell_bit;
            else      board_x <= board_x | cell_bit;
            move_cnt <= move_cnt + 4'd1;
         end
         if (state == CHECK) begin
            if (lines_mover != 8'd0) begin
               win_line <= lines_mover;
               winner   <= turn ? 2'b10 : 2'b01;
               isNotEnd <= 1'b0;
            end else if (move_cnt == 4'd9) begin
               winner   <= 2'b11;
               isNotEnd <= 1'b0;
            end else begin
               turn <= ~turn;
            end
         end
         // A forfeit awards the game to the player who was waiting.
         if (forfeit) begin
            winner   <= turn ? 2'b01 : 2'b10;
            isNotEnd <= 1'b0;
         end
      end
   end

`ifdef REF_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] to_cnt;

   assign timeout_hit = (state == WAIT) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Holds at the limit so an illegal attempt on the expiry cycle defers the forfeit by one cycle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                             to_cnt <= '0;
      else if (legal)                      to_cnt <= '0;
      else if (state == WAIT && !timeout_hit) to_cnt <= to_cnt + 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^32'(TIMEOUT_CYCLES);
   assign timeout_hit    = 1'b0;
`endif

endmodule
